uart_rx_param: RTL and testbench

- Parametrised UART receiver: configurable data width, oversampling ratio, parity mode and stop-bit count.
- Adds input synchronisation, 3-sample majority voting, false-start rejection, parity/framing/overrun detection and a valid/ready output handshake.
- Sits between the pad-side rx line and any byte consumer (FIFO, register bank).
- Oversample tick comes from the shared baud generator.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rx_param_if.sv | 29 ++
 rtl/uart_rx_sampler.sv | 63 ++++++
 rtl/uart_rx_param.sv | 158 +++++++++++++++
 tb/tb_uart_rx_param.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// Received-word handshake between the UART receiver and its consumer.
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 parity_err;
    logic                 frame_err;
    logic                 overrun;

    modport master (
        output rx_data,
        output rx_valid,
        output parity_err,
        output frame_err,
        output overrun,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  parity_err,
        input  frame_err,
        input  overrun,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_sampler.sv
// rx synchroniser, in-bit tick counter and 3-sample majority voter around mid-bit.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic rx_i,
    input  logic tick_i,
    input  logic restart_i,
    output logic rx_sync_o,
    output logic bit_value_o,
    output logic bit_strobe_o
);
    localparam int TW = cnt_width(OVERSAMPLE);
    localparam logic [TW-1:0] MID_LO = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] MID    = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] MID_HI = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [TW-1:0] TOP    = TW'(OVERSAMPLE - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [TW-1:0]          tcnt_q, tcnt_d;
    logic                   s_lo_q, s_lo_d;
    logic                   s_mid_q, s_mid_d;

    assign rx_sync_o = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '1;
            tcnt_q  <= '0;
            s_lo_q  <= 1'b1;
            s_mid_q <= 1'b1;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], rx_i};
            tcnt_q  <= tcnt_d;
            s_lo_q  <= s_lo_d;
            s_mid_q <= s_mid_d;
        end
    end

    always_comb begin
        tcnt_d  = tcnt_q;
        s_lo_d  = s_lo_q;
        s_mid_d = s_mid_q;
        if (tick_i) begin
            if (restart_i) begin
                tcnt_d = '0;
            end else begin
                tcnt_d = (tcnt_q == TOP) ? '0 : tcnt_q + 1'b1;
                if (tcnt_q == MID_LO) s_lo_d = rx_sync_o;
                if (tcnt_q == MID) s_mid_d = rx_sync_o;
            end
        end
    end

    // Third vote is the live synced sample on the decision tick itself.
    assign bit_strobe_o = tick_i && !restart_i && (tcnt_q == MID_HI);
    assign bit_value_o  = (s_lo_q & s_mid_q) | (s_lo_q & rx_sync_o) | (s_mid_q & rx_sync_o);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: frame FSM, shift register and valid/ready output stage.
//   state  | meaning
//   IDLE   | waiting for a 1->0 edge on the synced line
//   START  | validating the start bit at mid-bit
//   DATA   | shifting in DATA_BITS data bits, LSB first
//   PARITY | checking the parity bit
//   STOP   | sampling STOP_BITS stop bits; completes at the last decision
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rx_i,
    input  logic              tick_i,
    uart_rx_param_if.master   bus
);
    localparam int BW = cnt_width(DATA_BITS + 1);

    rx_state_e            state_q, state_d;
    logic [BW-1:0]        bcnt_q, bcnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 scnt_q, scnt_d;
    logic                 par_acc_q, par_acc_d;
    logic                 frm_acc_q, frm_acc_d;
    logic                 rx_prev_q, rx_prev_d;
    logic                 done_q, done_d;
    logic                 restart;

    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q, parity_err_q, frame_err_q, overrun_q;

    logic rx_sync, bit_value, bit_strobe;

    uart_rx_sampler #(
        .OVERSAMPLE  (OVERSAMPLE),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sampler (
        .clk          (clk),
        .reset_n      (reset_n),
        .rx_i         (rx_i),
        .tick_i       (tick_i),
        .restart_i    (restart),
        .rx_sync_o    (rx_sync),
        .bit_value_o  (bit_value),
        .bit_strobe_o (bit_strobe)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            bcnt_q    <= '0;
            shift_q   <= '0;
            scnt_q    <= 1'b0;
            par_acc_q <= 1'b0;
            frm_acc_q <= 1'b0;
            rx_prev_q <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bcnt_q    <= bcnt_d;
            shift_q   <= shift_d;
            scnt_q    <= scnt_d;
            par_acc_q <= par_acc_d;
            frm_acc_q <= frm_acc_d;
            rx_prev_q <= rx_prev_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bcnt_d    = bcnt_q;
        shift_d   = shift_q;
        scnt_d    = scnt_q;
        par_acc_d = par_acc_q;
        frm_acc_d = frm_acc_q;
        rx_prev_d = tick_i ? rx_sync : rx_prev_q;
        done_d    = 1'b0;
        restart   = 1'b0;

        case (state_q)
            IDLE: begin
                // Edge-triggered so a held-low line (break) cannot retrigger.
                if (tick_i && !rx_sync && rx_prev_q) begin
                    state_d   = START;
                    restart   = 1'b1;
                    bcnt_d    = '0;
                    scnt_d    = 1'b0;
                    par_acc_d = 1'b0;
                    frm_acc_d = 1'b0;
                end
            end
            START: begin
                if (bit_strobe) state_d = bit_value ? IDLE : DATA;
            end
            DATA: begin
                if (bit_strobe) begin
                    shift_d = {bit_value, shift_q[DATA_BITS-1:1]};
                    bcnt_d  = bcnt_q + 1'b1;
                    if (bcnt_q == BW'(DATA_BITS - 1))
                        state_d = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (bit_strobe) begin
                    par_acc_d = (^shift_q) ^ bit_value ^ (PARITY_MODE == PARITY_ODD);
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (bit_strobe) begin
                    if (!bit_value) frm_acc_d = 1'b1;
                    if (scnt_q == 1'(STOP_BITS - 1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        scnt_d = scnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (done_q && (!rx_valid_q || bus.rx_ready)) begin
                rx_data_q    <= shift_q;
                parity_err_q <= par_acc_q;
                frame_err_q  <= frm_acc_q;
                rx_valid_q   <= 1'b1;
            end else begin
                if (rx_valid_q && bus.rx_ready) rx_valid_q <= 1'b0;
                if (done_q) overrun_q <= 1'b1;
            end
        end
    end

    assign bus.rx_data    = rx_data_q;
    assign bus.rx_valid   = rx_valid_q;
    assign bus.parity_err = parity_err_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench: three receiver configurations (8N1, 8E1, 7O2) on a shared clock and tick.
module tb_uart_rx_param;
    import uart_pkg::*;

    localparam int TICK_DIV = 4;
    localparam int BIT_CLKS = 16 * TICK_DIV;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [1:0] tdiv = '0;
    logic tick;
    logic rx_a = 1'b1, rx_b = 1'b1, rx_c = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;

    int           cap_cnt [3] = '{0, 0, 0};
    int           ovr_cnt [3] = '{0, 0, 0};
    int           vcyc    [3] = '{0, 0, 0};
    logic [8:0]   cap_data[3];
    logic         cap_perr[3];
    logic         cap_ferr[3];

    always #5 clk = ~clk;
    always @(posedge clk) tdiv <= tdiv + 2'd1;
    assign tick = (tdiv == 2'd3);

    uart_rx_param_if #(.DATA_BITS(8)) bus_a ();
    uart_rx_param_if #(.DATA_BITS(8)) bus_b ();
    uart_rx_param_if #(.DATA_BITS(7)) bus_c ();

    uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_MODE(0), .STOP_BITS(1), .SYNC_STAGES(2))
        u_a (.clk(clk), .reset_n(reset_n), .rx_i(rx_a), .tick_i(tick), .bus(bus_a));
    uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_MODE(2), .STOP_BITS(1), .SYNC_STAGES(2))
        u_b (.clk(clk), .reset_n(reset_n), .rx_i(rx_b), .tick_i(tick), .bus(bus_b));
    uart_rx_param #(.DATA_BITS(7), .OVERSAMPLE(16), .PARITY_MODE(1), .STOP_BITS(2), .SYNC_STAGES(2))
        u_c (.clk(clk), .reset_n(reset_n), .rx_i(rx_c), .tick_i(tick), .bus(bus_c));

    always @(negedge clk) begin
        if (bus_a.rx_valid) vcyc[0]++;
        if (bus_b.rx_valid) vcyc[1]++;
        if (bus_c.rx_valid) vcyc[2]++;
        if (bus_a.rx_valid && bus_a.rx_ready) begin
            cap_cnt[0]++; cap_data[0] = {1'b0, bus_a.rx_data};
            cap_perr[0] = bus_a.parity_err; cap_ferr[0] = bus_a.frame_err;
        end
        if (bus_b.rx_valid && bus_b.rx_ready) begin
            cap_cnt[1]++; cap_data[1] = {1'b0, bus_b.rx_data};
            cap_perr[1] = bus_b.parity_err; cap_ferr[1] = bus_b.frame_err;
        end
        if (bus_c.rx_valid && bus_c.rx_ready) begin
            cap_cnt[2]++; cap_data[2] = {2'b0, bus_c.rx_data};
            cap_perr[2] = bus_c.parity_err; cap_ferr[2] = bus_c.frame_err;
        end
        if (bus_a.overrun) ovr_cnt[0]++;
        if (bus_b.overrun) ovr_cnt[1]++;
        if (bus_c.overrun) ovr_cnt[2]++;
    end

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_rx(input int sel, input logic v);
        case (sel)
            0:       rx_a = v;
            1:       rx_b = v;
            default: rx_c = v;
        endcase
    endtask

    task automatic drive_bit(input int sel, input logic b);
        @(negedge clk);
        set_rx(sel, b);
        repeat (BIT_CLKS - 1) @(negedge clk);
    endtask

    task automatic idle_bits(input int n);
        repeat (n * BIT_CLKS) @(negedge clk);
    endtask

    task automatic send_frame(input int sel, input logic [8:0] data, input int nbits,
                              input bit has_par, input logic pbit,
                              input logic s1, input logic s2, input int nstop);
        drive_bit(sel, 1'b0);
        for (int i = 0; i < nbits; i++) drive_bit(sel, data[i]);
        if (has_par) drive_bit(sel, pbit);
        drive_bit(sel, s1);
        if (nstop == 2) drive_bit(sel, s2);
        set_rx(sel, 1'b1);
    endtask

    int c0, v0, o0;

    initial begin
        bus_a.rx_ready = 1'b0;
        bus_b.rx_ready = 1'b1;
        bus_c.rx_ready = 1'b1;
        repeat (5) @(negedge clk);

        chk("rst_data",  bus_a.rx_data, 0);
        chk("rst_valid", bus_a.rx_valid, 0);
        chk("rst_perr",  bus_b.parity_err, 0);
        chk("rst_ferr",  bus_c.frame_err, 0);
        chk("rst_ovr",   bus_a.overrun, 0);
        reset_n = 1'b1;
        idle_bits(1);

        // 8N1 0xA5 with consumer always ready
        bus_a.rx_ready = 1'b1;
        c0 = cap_cnt[0]; v0 = vcyc[0];
        send_frame(0, 9'h0A5, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1);
        idle_bits(2);
        chk("a5_cnt",   cap_cnt[0] - c0, 1);
        chk("a5_data",  cap_data[0], 'hA5);
        chk("a5_perr",  cap_perr[0], 0);
        chk("a5_ferr",  cap_ferr[0], 0);
        chk("a5_vcyc",  vcyc[0] - v0, 1);

        // 8E1: 0xA5 has four ones, so parity bit 1 is wrong and 0 is right
        send_frame(1, 9'h0A5, 8, 1'b1, 1'b1, 1'b1, 1'b1, 1);
        idle_bits(2);
        chk("e_bad_data", cap_data[1], 'hA5);
        chk("e_bad_perr", cap_perr[1], 1);
        c0 = cap_cnt[1];
        send_frame(1, 9'h0A5, 8, 1'b1, 1'b0, 1'b1, 1'b1, 1);
        idle_bits(2);
        chk("e_ok_cnt",  cap_cnt[1] - c0, 1);
        chk("e_ok_perr", cap_perr[1], 0);

        // False start: 5 ticks low
        c0 = cap_cnt[0];
        @(negedge clk);
        set_rx(0, 1'b0);
        repeat (5 * TICK_DIV) @(negedge clk);
        set_rx(0, 1'b1);
        idle_bits(2);
        chk("fs_cnt",   cap_cnt[0] - c0, 0);
        chk("fs_state", int'(u_a.state_q), int'(IDLE));
        send_frame(0, 9'h03C, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1);
        idle_bits(2);
        chk("fs_next",  cap_data[0], 'h3C);

        // Overrun: consumer stalled across two frames
        bus_a.rx_ready = 1'b0;
        c0 = cap_cnt[0]; o0 = ovr_cnt[0];
        send_frame(0, 9'h011, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1);
        send_frame(0, 9'h022, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1);
        idle_bits(2);
        chk("ov_data",  bus_a.rx_data, 'h11);
        chk("ov_valid", bus_a.rx_valid, 1);
        chk("ov_pulse", ovr_cnt[0] - o0, 1);
        bus_a.rx_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("ov_acc_cnt",  cap_cnt[0] - c0, 1);
        chk("ov_acc_data", cap_data[0], 'h11);
        chk("ov_valid_lo", bus_a.rx_valid, 0);

        // 7O2: 0x3C has four ones, odd parity bit 1 is correct; second stop low
        c0 = cap_cnt[2];
        send_frame(2, 9'h03C, 7, 1'b1, 1'b1, 1'b1, 1'b0, 2);
        idle_bits(2);
        chk("o2_cnt",  cap_cnt[2] - c0, 1);
        chk("o2_data", cap_data[2], 'h3C);
        chk("o2_perr", cap_perr[2], 0);
        chk("o2_ferr", cap_ferr[2], 1);

        // Reset during data bit 4
        c0 = cap_cnt[0];
        drive_bit(0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(0, 1'b1);
        @(negedge clk);
        set_rx(0, 1'b1);
        repeat (BIT_CLKS / 2) @(negedge clk);
        reset_n = 1'b0;
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        chk("rm_state", int'(u_a.state_q), int'(IDLE));
        idle_bits(2);
        chk("rm_cnt", cap_cnt[0] - c0, 0);
        send_frame(0, 9'h05A, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1);
        idle_bits(2);
        chk("rm_next_cnt",  cap_cnt[0] - c0, 1);
        chk("rm_next_data", cap_data[0], 'h5A);
        chk("rm_next_ferr", cap_ferr[0], 0);
        chk("rm_next_perr", cap_perr[0], 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
